// File: rtl/seg_disp_sched.sv
// Scan scheduler for a 3-digit multiplexed 7-segment display with PWM dimming.
// Arbitrates between a free-running background value and a held priority message.
module seg_disp_sched #(
    parameter int SCAN_DIV    = 16384,
    parameter int BLANK_CYC   = 256,
    parameter int HOLD_FRAMES = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [11:0] a_data,
    input  logic        b_req,
    input  logic [11:0] b_data,
    output logic        b_ack,
    output logic        b_busy,
    input  logic [3:0]  bright,
    output logic [7:0]  seg,
    output logic [2:0]  digitn,
    output logic        frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYC);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_FRAMES);

    typedef enum logic {
        SRC_A,
        SRC_B
    } src_e;

    src_e          src_q, src_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pend_q, pend_d;
    logic          init_q, init_d;
    logic [11:0]   msg_q, msg_d;
    logic [11:0]   val_f_q, val_f_d;
    logic [3:0]    bright_f_q, bright_f_d;
    logic          b_ack_q, b_ack_d;
    logic          b_busy_q, b_busy_d;
    logic          frame_tick_q, frame_tick_d;
    logic [7:0]    seg_q, seg_d;
    logic [2:0]    digitn_q, digitn_d;

    logic          slot_end;
    logic          bnd;
    logic          acc;
    logic          en;
    logic          leave;
    logic [3:0]    nib;
    logic [2:0]    dig;

    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hA7;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        src_d        = src_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        pend_d       = pend_q;
        init_d       = init_q;
        msg_d        = msg_q;
        val_f_d      = val_f_q;
        bright_f_d   = bright_f_q;
        b_busy_d     = b_busy_q;
        leave        = 1'b0;
        nib          = val_f_q[11:8];
        dig          = 3'b001;

        slot_end = (cnt_q == CNT_MAX);
        bnd      = slot_end && (idx_q == 2'd2);
        acc      = b_req && !b_ack_q;

        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        case (idx_q)
            2'd0: begin
                nib = val_f_q[3:0];
                dig = 3'b100;
            end
            2'd1: begin
                nib = val_f_q[7:4];
                dig = 3'b010;
            end
            default: begin
                nib = val_f_q[11:8];
                dig = 3'b001;
            end
        endcase

        // Low nibble of the slot counter doubles as the 16-step PWM phase.
        en = (cnt_q >= BLANK) &&
             ((bright_f_q == 4'hF) || (cnt_q[3:0] < bright_f_q));

        digitn_d     = en ? dig : 3'b000;
        seg_d        = en ? hex2seg(nib) : 8'hFF;
        frame_tick_d = bnd;
        b_ack_d      = acc;

        if (init_q) begin
            init_d     = 1'b0;
            val_f_d    = a_data;
            bright_f_d = bright;
        end else if (bnd) begin
            bright_f_d = bright;
            if (pend_q) begin
                src_d   = SRC_B;
                hold_d  = HOLD_LD;
                pend_d  = 1'b0;
                val_f_d = msg_q;
            end else if (src_q == SRC_B) begin
                hold_d = hold_q - HW'(1);
                if (hold_q == HW'(1)) begin
                    src_d   = SRC_A;
                    val_f_d = a_data;
                    leave   = 1'b1;
                end
            end else begin
                val_f_d = a_data;
            end
        end

        // A boundary sees the pre-acceptance state; a new message waits a frame.
        if (leave) begin
            b_busy_d = 1'b0;
        end
        if (acc) begin
            msg_d    = b_data;
            pend_d   = 1'b1;
            b_busy_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            src_q        <= SRC_A;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            hold_q       <= '0;
            pend_q       <= 1'b0;
            init_q       <= 1'b1;
            msg_q        <= '0;
            val_f_q      <= '0;
            bright_f_q   <= '0;
            b_ack_q      <= 1'b0;
            b_busy_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_q        <= 8'hFF;
            digitn_q     <= 3'b000;
        end else begin
            src_q        <= src_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            pend_q       <= pend_d;
            init_q       <= init_d;
            msg_q        <= msg_d;
            val_f_q      <= val_f_d;
            bright_f_q   <= bright_f_d;
            b_ack_q      <= b_ack_d;
            b_busy_q     <= b_busy_d;
            frame_tick_q <= frame_tick_d;
            seg_q        <= seg_d;
            digitn_q     <= digitn_d;
        end
    end

    assign seg        = seg_q;
    assign digitn     = digitn_q;
    assign b_ack      = b_ack_q;
    assign b_busy     = b_busy_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Bench for seg_disp_sched: frame-level reference model compared every cycle,
// plus directed literal checks at hand-picked cycles.
module tb_seg_disp_sched;

    localparam int SCAN  = 32;
    localparam int BLANK = 4;
    localparam int HOLD  = 2;
    localparam int FRAME = 3 * SCAN;

    localparam logic [7:0] DEC [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E
    };

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [11:0] a_data;
    logic        b_req;
    logic [11:0] b_data;
    logic        b_ack;
    logic        b_busy;
    logic [3:0]  bright;
    logic [7:0]  seg;
    logic [2:0]  digitn;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int pc;

    seg_disp_sched #(
        .SCAN_DIV(SCAN),
        .BLANK_CYC(BLANK),
        .HOLD_FRAMES(HOLD)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .a_data(a_data),
        .b_req(b_req),
        .b_data(b_data),
        .b_ack(b_ack),
        .b_busy(b_busy),
        .bright(bright),
        .seg(seg),
        .digitn(digitn),
        .frame_tick(frame_tick)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) pc <= 0;
        else            pc <= pc + 1;
    end

    // Reference model: time since release, frame contents, message bookkeeping.
    int          m_t;
    bit          m_first;
    logic [11:0] m_show;
    logic [3:0]  m_br;
    bit          m_cur_b;
    int          m_left;
    bit          m_pend;
    logic [11:0] m_msg;
    logic [7:0]  e_seg;
    logic [2:0]  e_dig;
    logic        e_tick;
    logic        e_ack;
    logic        e_busy;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        int pos, s, c;
        bit on, acc;
        if (!sys_rst_n) begin
            m_t     = 0;
            m_first = 1;
            m_show  = '0;
            m_br    = '0;
            m_cur_b = 0;
            m_left  = 0;
            m_pend  = 0;
            m_msg   = '0;
            e_seg   = 8'hFF;
            e_dig   = 3'b000;
            e_tick  = 1'b0;
            e_ack   = 1'b0;
            e_busy  = 1'b0;
        end else begin
            pos = m_t % FRAME;
            s   = pos / SCAN;
            c   = pos % SCAN;
            on  = (c >= BLANK) && ((m_br == 4'hF) || ((c % 16) < int'(m_br)));
            e_dig  = on ? 3'(3'b100 >> s) : 3'b000;
            e_seg  = on ? DEC[m_show[4*s +: 4]] : 8'hFF;
            e_tick = (pos == FRAME - 1);
            acc    = b_req && !e_ack;
            if (m_first) begin
                m_first = 0;
                m_show  = a_data;
                m_br    = bright;
            end else if (pos == FRAME - 1) begin
                m_br = bright;
                if (m_pend) begin
                    m_show  = m_msg;
                    m_cur_b = 1;
                    m_left  = HOLD - 1;
                    m_pend  = 0;
                end else if (m_cur_b && m_left > 0) begin
                    m_left--;
                end else begin
                    m_cur_b = 0;
                    m_show  = a_data;
                end
            end
            if (acc) begin
                m_msg  = b_data;
                m_pend = 1;
            end
            e_ack  = acc;
            e_busy = m_pend || m_cur_b;
            m_t++;
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (pc=%0d t=%0t)", name, act, exp, pc, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        chk("model_seg", 12'(seg), 12'(e_seg));
        chk("model_digitn", 12'(digitn), 12'(e_dig));
        chk("model_tick", 12'(frame_tick), 12'(e_tick));
        chk("model_ack", 12'(b_ack), 12'(e_ack));
        chk("model_busy", 12'(b_busy), 12'(e_busy));
    end

    task automatic wait_pc(input int n);
        while (pc < n) @(negedge sys_clk);
    endtask

    initial begin
        sys_rst_n = 1'b1;
        a_data    = 12'h123;
        bright    = 4'hF;
        b_req     = 1'b0;
        b_data    = 12'h000;
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_seg", 12'(seg), 12'h0FF);
        chk("rst_digitn", 12'(digitn), 12'h000);
        chk("rst_busy", 12'(b_busy), 12'h000);
        sys_rst_n = 1'b1;

        wait_pc(1);
        chk("first_blank", 12'(digitn), 12'h000);
        wait_pc(10);
        chk("s0_dig", 12'(digitn), 12'h004);
        chk("s0_seg", 12'(seg), 12'h0B0);
        wait_pc(32);
        chk("s0_last", 12'(seg), 12'h0B0);
        wait_pc(33);
        chk("s1_blank_dig", 12'(digitn), 12'h000);
        chk("s1_blank_seg", 12'(seg), 12'h0FF);
        wait_pc(36);
        chk("s1_blank_end", 12'(digitn), 12'h000);
        wait_pc(37);
        chk("s1_dig", 12'(digitn), 12'h002);
        chk("s1_seg", 12'(seg), 12'h0A4);
        wait_pc(70);
        chk("s2_dig", 12'(digitn), 12'h001);
        chk("s2_seg", 12'(seg), 12'h0F9);
        wait_pc(96);
        chk("tick_96", 12'(frame_tick), 12'h001);
        wait_pc(97);
        chk("tick_97", 12'(frame_tick), 12'h000);

        wait_pc(100);
        bright = 4'd4;
        wait_pc(106);
        chk("bright_midframe", 12'(digitn), 12'h004);
        wait_pc(192);
        chk("tick_192", 12'(frame_tick), 12'h001);
        wait_pc(200);
        bright = 4'd0;
        wait_pc(202);
        chk("pwm_off", 12'(digitn), 12'h000);
        wait_pc(210);
        chk("pwm_on", 12'(seg), 12'h0B0);
        wait_pc(300);
        bright = 4'hF;
        wait_pc(306);
        chk("dark", 12'(digitn), 12'h000);

        wait_pc(400);
        b_req  = 1'b1;
        b_data = 12'hABC;
        wait_pc(401);
        chk("ack", 12'(b_ack), 12'h001);
        chk("busy_set", 12'(b_busy), 12'h001);
        b_req = 1'b0;
        wait_pc(491);
        chk("msg_d0", 12'(seg), 12'h0A7);
        wait_pc(619);
        chk("msg_d1", 12'(seg), 12'h083);
        wait_pc(671);
        chk("busy_hold", 12'(b_busy), 12'h001);
        wait_pc(672);
        chk("busy_drop", 12'(b_busy), 12'h000);
        wait_pc(683);
        chk("back_to_a", 12'(seg), 12'h0B0);

        wait_pc(780);
        b_req  = 1'b1;
        b_data = 12'hABC;
        wait_pc(781);
        b_req = 1'b0;
        wait_pc(875);
        chk("t5_abc", 12'(seg), 12'h0A7);
        wait_pc(900);
        b_req  = 1'b1;
        b_data = 12'h456;
        wait_pc(901);
        chk("t5_ack", 12'(b_ack), 12'h001);
        b_req = 1'b0;
        wait_pc(971);
        chk("t5_456_f1", 12'(seg), 12'h082);
        wait_pc(1067);
        chk("t5_456_f2", 12'(seg), 12'h082);
        wait_pc(1151);
        chk("t5_busy_hold", 12'(b_busy), 12'h001);
        wait_pc(1152);
        chk("t5_busy_drop", 12'(b_busy), 12'h000);
        wait_pc(1163);
        chk("t5_back_a", 12'(seg), 12'h0B0);

        for (int k = 0; k < 5; k++) begin
            wait_pc(1180 + k);
            b_req  = 1'b1;
            b_data = 12'(12'h780 + k);
        end
        wait_pc(1185);
        b_req = 1'b0;
        wait_pc(1259);
        chk("held_req_last", 12'(seg), 12'h099);

        wait_pc(1300);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_seg", 12'(seg), 12'h0FF);
        chk("async_dig", 12'(digitn), 12'h000);
        chk("async_busy", 12'(b_busy), 12'h000);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_pc(10);
        chk("post_rst_seg", 12'(seg), 12'h0B0);
        chk("post_rst_busy", 12'(b_busy), 12'h000);
        wait_pc(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
